array_sp_gen: RTL and testbench

ARRAY_SP_GEN -- requirements
Module: array_sp_gen

---
 rtl/array_sp_gen.sv | 110 +++++++++++
 tb/tb_array_sp_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_sp_gen.sv
// Single-port RAM wrapper with lane write masks, a zeroing sweep after reset,
// and a fixed-latency read pipeline (1 + OUT_REG cycles).
module array_sp_gen #(
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 76,
    parameter int MASK_GRAN = 19,
    parameter int OUT_REG   = 0,
    localparam int MASK_W   = WIDTH / MASK_GRAN,
    localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              RW0_clk,
    input  logic              RW0_reset,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [WIDTH-1:0]  RW0_wdata,
    output logic [WIDTH-1:0]  RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready
);

    // state      | meaning
    // ST_INIT    | sweeping zeros into entry init_cnt, requests ignored
    // ST_READY   | array accepts reads and masked writes
    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [WIDTH-1:0]  ram [DEPTH];

    logic             in_range;
    logic             wr_req;
    logic             rd_req;
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    assign in_range = int'(RW0_addr) < DEPTH;
    assign wr_req   = RW0_ready & RW0_en & RW0_wmode;
    assign rd_req   = RW0_ready & RW0_en & ~RW0_wmode;

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            RW0_ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_READY;
                        init_cnt  <= '0;
                        RW0_ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_READY: RW0_ready <= 1'b1;
                default: begin
                    state     <= ST_INIT;
                    init_cnt  <= '0;
                    RW0_ready <= 1'b0;
                end
            endcase
        end
    end

    // Contents are never reset directly; the INIT sweep defines them.
    always_ff @(posedge RW0_clk) begin
        if (!RW0_reset) begin
            if (state == ST_INIT) begin
                ram[init_cnt] <= '0;
            end else if (wr_req && in_range) begin
                for (int i = 0; i < MASK_W; i++) begin
                    if (RW0_wmask[i])
                        ram[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req)
                s1_data <= in_range ? ram[RW0_addr] : '0;
        end
    end

    // Data registers only load on a completing read, so rdata holds otherwise.
    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge RW0_clk) begin
            if (RW0_reset) begin
                RW0_rvalid <= 1'b0;
                RW0_rdata  <= '0;
            end else begin
                RW0_rvalid <= s1_valid;
                if (s1_valid)
                    RW0_rdata <= s1_data;
            end
        end
    end else begin : g_no_out_reg
        assign RW0_rvalid = s1_valid;
        assign RW0_rdata  = s1_data;
    end

endmodule

// File: tb/tb_array_sp_gen.sv
// Bench for array_sp_gen: instance A (512 deep, OUT_REG=0) and instance B
// (300 deep, OUT_REG=1) share stimulus; sel chooses which one is checked.
module tb_array_sp_gen;
    localparam int W = 76;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         wmode = 1'b0;
    logic [8:0]   addr = '0;
    logic [3:0]   wmask = '0;
    logic [W-1:0] wdata = '0;
    int           sel = 0;

    logic [W-1:0] a_rdata, b_rdata;
    logic         a_rvalid, b_rvalid, a_ready, b_ready;

    logic rst_q = 1'b1;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrs = 0;
    logic [W-1:0] hold = '0;

    typedef struct {
        logic         en;
        logic         wmode;
        logic [8:0]   addr;
        logic [3:0]   wmask;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } sb_t;

    sb_t sbq[$];

    array_sp_gen u_a (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(a_rdata), .RW0_rvalid(a_rvalid), .RW0_ready(a_ready)
    );

    array_sp_gen #(.DEPTH(300), .WIDTH(76), .MASK_GRAN(19), .OUT_REG(1)) u_b (
        .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en),
        .RW0_wmode(wmode), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(b_rdata), .RW0_rvalid(b_rvalid), .RW0_ready(b_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= cyc + 1;
    end

    function automatic logic rdy();
        return (sel == 1) ? b_ready : a_ready;
    endfunction

    function automatic int lat();
        return (sel == 1) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t wr(input logic [8:0] a, input logic [3:0] m, input logic [W-1:0] d);
        return '{en: 1'b1, wmode: 1'b1, addr: a, wmask: m, wdata: d, exp: '0};
    endfunction

    function automatic vec_t rd(input logic [8:0] a, input logic [W-1:0] e);
        return '{en: 1'b1, wmode: 1'b0, addr: a, wmask: 4'h0, wdata: '0, exp: e};
    endfunction

    function automatic vec_t idle();
        return '{en: 1'b0, wmode: 1'b0, addr: '0, wmask: 4'h0, wdata: '0, exp: '0};
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        en = v.en; wmode = v.wmode; addr = v.addr; wmask = v.wmask; wdata = v.wdata;
        if (v.en && !v.wmode)
            sbq.push_back('{due: cyc + lat(), data: v.exp});
    endtask

    // Requests stay asserted (read of addr 5) through reset and the INIT sweep.
    task automatic pulse_reset(input int s);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; wmode = 1'b0; addr = 9'd5;
        @(negedge clk);
        rst = 1'b0; sel = s;
    endtask

    task automatic expect_ready(input int depth, input string name);
        int n;
        n = 0;
        while (rdy() !== 1'b1 && n < depth + 20) begin
            @(negedge clk);
            n++;
        end
        nchecks++;
        if (n != depth) begin
            nerrs++;
            $display("FAIL %s: ready after %0d cycles, expected %0d", name, n, depth);
        end
        if (rdy() === 1'b1)
            sbq.push_back('{due: cyc + lat(), data: '0});
    endtask

    // Output checker: every negedge, rvalid/rdata against the scoreboard head.
    initial begin
        logic         v;
        logic [W-1:0] d;
        sb_t          it;
        forever begin
            @(negedge clk);
            v = (sel == 1) ? b_rvalid : a_rvalid;
            d = (sel == 1) ? b_rdata : a_rdata;
            if (rst_q) begin
                sbq.delete();
                hold = '0;
                chk("reset_rvalid", W'(v), '0);
                chk("reset_rdata", d, '0);
            end else if (sbq.size() != 0 && sbq[0].due == cyc) begin
                it = sbq.pop_front();
                chk("read_rvalid", W'(v), W'(1));
                chk("read_rdata", d, it.data);
                hold = it.data;
            end else begin
                chk("idle_rvalid", W'(v), '0);
                chk("hold_rdata", d, hold);
            end
        end
    end

    initial begin
        vec_t ta[$];
        vec_t tb_vecs[$];
        logic [W-1:0] d1, d2, d3, d4, d5, d6, d7, da, db;

        d1 = {4{19'h12345}};
        d2 = {4{19'h0ABCD}};
        d3 = {4{19'h54321}};
        d4 = {19'h11111, 19'h22222, 19'h33333, 19'h44444};
        d5 = {4{19'h7EEEE}};
        d6 = {19'h0F00F, 19'h70707, 19'h01010, 19'h2AAAA};
        d7 = {19'h7A5A5, 19'h1C3C3, 19'h6E1E1, 19'h0F0F0};
        da = {4{19'h3C3C3}};
        db = {19'h7FFFF, 19'h12121, 19'h34343, 19'h56565};

        ta.push_back(wr(9'h1FF, 4'b0101, ONES));
        ta.push_back(rd(9'h1FF, {19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF}));
        ta.push_back(wr(9'd1, 4'hF, d1));
        ta.push_back(wr(9'd2, 4'hF, d2));
        ta.push_back(wr(9'd3, 4'hF, d3));
        ta.push_back(rd(9'd1, d1));
        ta.push_back(rd(9'd2, d2));
        ta.push_back(rd(9'd3, d3));
        ta.push_back(idle());
        ta.push_back(idle());
        ta.push_back(idle());
        ta.push_back(wr(9'd4, 4'hF, d4));
        ta.push_back(wr(9'd4, 4'h0, d5));
        ta.push_back(rd(9'd4, d4));
        ta.push_back(wr(9'd6, 4'hF, d6));
        ta.push_back(rd(9'd6, d6));
        ta.push_back(wr(9'd8, 4'b0010, d7));
        ta.push_back(rd(9'd8, {19'h0, 19'h0, 19'h6E1E1, 19'h0}));
        ta.push_back(rd(9'd5, '0));
        ta.push_back(wr(9'd7, 4'hF, d1));
        ta.push_back(rd(9'd7, d1));
        ta.push_back(idle());
        ta.push_back(idle());

        tb_vecs.push_back(wr(9'd299, 4'hF, da));
        tb_vecs.push_back(wr(9'd310, 4'hF, ONES));
        tb_vecs.push_back(rd(9'd310, '0));
        tb_vecs.push_back(rd(9'd299, da));
        tb_vecs.push_back(rd(9'd0, '0));
        tb_vecs.push_back(rd(9'd54, '0));
        tb_vecs.push_back(rd(9'd298, '0));
        tb_vecs.push_back(wr(9'd20, 4'b1001, db));
        tb_vecs.push_back(rd(9'd20, {19'h7FFFF, 19'h0, 19'h0, 19'h56565}));
        tb_vecs.push_back(idle());
        tb_vecs.push_back(idle());
        tb_vecs.push_back(idle());

        // Instance A: restart the sweep part-way through INIT.
        pulse_reset(0);
        repeat (99) @(negedge clk);
        pulse_reset(0);
        expect_ready(512, "ready_a_after_midinit_reset");

        foreach (ta[i]) apply(ta[i]);

        // Reset in READY must re-zero addr 7.
        pulse_reset(0);
        expect_ready(512, "ready_a_after_ready_reset");
        apply(rd(9'd7, '0));
        apply(idle());
        apply(idle());

        // Instance B: non-power-of-2 depth, registered output.
        pulse_reset(1);
        expect_ready(300, "ready_b");

        foreach (tb_vecs[i]) apply(tb_vecs[i]);

        // Reset lands while a read is in flight; the pending result must vanish.
        apply(rd(9'd299, da));
        pulse_reset(1);
        expect_ready(300, "ready_b_after_inflight_reset");
        apply(rd(9'd299, '0));
        apply(idle());
        apply(idle());
        apply(idle());
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
